y_word_packer: RTL
==================

# y_word_packer

Downstream consumer of the XOR stage's 1-bit Y result stream. Accepts result bits over the Y_data/Y_enable/Y_ready handshake and packs them LSB-first into WIDTH-bit words. Buffers up to DEPTH packed words and presents them on a word-wide W handshake to the next stage (scoreboard/bus writer). A flush input emits a partial word tagged with its valid-bit count.

## Interface
- WIDTH, 8: bits per packed word; ≥2.
- DEPTH, 4: word FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Y_data  in  1  result bit from the upstream stage.
- Y_enable  in  1  Y_data valid.
- Y_ready  out  1  packer can accept a bit.
- flush  in  1  level; close the current partial word.
- W_data  out  WIDTH  head-of-FIFO word.
- W_count  out  $clog2(WIDTH+1)  valid bits in W_data (1..WIDTH).
- W_enable  out  1  FIFO non-empty.
- W_ready  in  1  downstream accepts the word.
- level  out  $clog2(DEPTH+1)  words currently buffered.

## Operation
- Bit accept: on an edge with Y_enable && Y_ready, Y_data is written to assembler bit bit_cnt, and bit_cnt increments.
- Word complete: when the accepted bit is bit WIDTH-1, the word is pushed with W_count=WIDTH on that same edge. The assembler and bit_cnt are cleared.
- Y_ready = !(bit_cnt==WIDTH-1 && full). It is a function of registered state only; there is no combinational path from W_ready.
- Flush: on an edge with flush=1, the partial word is pushed zero-padded with W_count = number of bits held, and the assembler is cleared. The edge must satisfy both of the following:
  - effective bit count >0 (held bits plus any bit accepted that edge);
  - FIFO not full.
- Flush boundary cases:
  - A bit accepted on the flush edge is included in the pushed word.
  - If flush is asserted while full, nothing is pushed; bit acceptance follows the normal rule.
  - Flush with zero bits is a no-op.
- Pop: on an edge with W_enable && W_ready, the head is removed.
- Full and pop on the same edge: the pop completes, but no push occurs that edge, because Y_ready was already low.
- Push and pop on the same edge (non-full): level is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; a separate count register drives full, empty and level.
- W_data/W_count hold the head entry while W_enable=1 and W_ready=0.

## Timing
- Reset values: Y_ready=1, W_enable=0, W_data=0, W_count=0, level=0, bit_cnt=0.
- Latency: a word is visible on W_enable/W_data the cycle after the edge that accepted its last bit (or flush).
- Throughput: one bit per cycle in; one word per cycle out.
- Y_ready updates the cycle after the pop that frees a slot.
- Reset mid-operation drops all buffered words and partial bits; no output glitches to a non-reset value while reset is high.

## Structure
- Shared package y_stream_pkg:
  - default WIDTH/DEPTH constants;
  - count-width helper function;
  - packed word struct (data, count).
- Sub-module y_word_fifo: synchronous DEPTH-entry FIFO with push, pop, full, empty and level.
- Top level holds the assembler, bit_cnt, flush logic and Y_ready.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset: pulse reset → Y_ready=1, W_enable=0, level=0, W_data=0.
- Pack: bits 1,0,1,1,0,0,1,0 on consecutive cycles with W_ready=1 → W_data=8'h4D, W_count=8, W_enable high exactly one cycle after the 8th accept.
- Backpressure: W_ready=0, stream 39 ones.
  - Expect level=4 and bit_cnt=7, then Y_ready=0; the 40th bit is held.
  - Raise W_ready for one cycle → pops 8'hFF; Y_ready=1 next cycle.
  - The 40th bit is accepted → level=4 again.
- Flush: bits 1,1,0 then flush → W_data=8'h03, W_count=3. A second flush with bit_cnt=0 → level unchanged.
- Flush coincident with a bit: bits 1,0, then bit 1 with flush=1 on the same edge → W_data=8'h05, W_count=3.
- Reset mid-operation: with level=2 and bit_cnt=5, assert reset.
  - W_enable=0 and level=0 before the next clock edge.
  - Afterwards, 8 bits of 8'hA5 yield exactly one word 8'hA5, count 8.

Source files
------------

// File: rtl/y_stream_pkg.sv
// Shared definitions for the Y result-stream packer: default sizes, count-width helper
// and the packed word payload.
package y_stream_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CW    = $clog2(DEF_WIDTH + 1);

    // Bits needed to hold any value 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic [DEF_CW-1:0]    count;
        logic [DEF_WIDTH-1:0] data;
    } y_word_t;

endpackage

// File: rtl/y_word_fifo.sv
// Synchronous DEPTH-entry word FIFO; pointers wrap naturally, a separate occupancy
// count drives full, empty and level.
module y_word_fifo
    import y_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Empty FIFO presents zero so the head never shows stale or reset-undefined storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/y_word_packer.sv
// Packs the 1-bit Y result stream LSB-first into WIDTH-bit words, buffers them and
// presents them on the W handshake; flush closes a partial word with its bit count.
module y_word_packer
    import y_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Y_data,
    input  logic                         Y_enable,
    output logic                         Y_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             W_data,
    output logic [$clog2(WIDTH+1)-1:0]   W_count,
    output logic                         W_enable,
    input  logic                         W_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned EW = WIDTH + CW;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] assembler;
    logic [WIDTH-1:0] asm_next;
    logic [CW-1:0]    eff_cnt;
    logic             accept;
    logic             word_done;
    logic             push;
    logic             full;
    logic             empty;
    logic [EW-1:0]    head;

    // Only the last bit slot can stall, and only while the FIFO is full.
    assign Y_ready = !((bit_cnt == CW'(WIDTH - 1)) && full);

    always_comb begin
        accept   = Y_enable && Y_ready;
        asm_next = assembler;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (accept && (bit_cnt == CW'(i))) asm_next[i] = Y_data;
        end
        eff_cnt   = bit_cnt + CW'(accept);
        word_done = accept && (bit_cnt == CW'(WIDTH - 1));
        // A full word implies the FIFO had room; flush needs room and at least one bit.
        push      = word_done || (flush && !full && (eff_cnt != '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            assembler <= '0;
        end else if (push) begin
            bit_cnt   <= '0;
            assembler <= '0;
        end else if (accept) begin
            bit_cnt   <= eff_cnt;
            assembler <= asm_next;
        end
    end

    y_word_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({eff_cnt, asm_next}),
        .pop       (W_ready),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign W_enable = !empty;
    assign W_data   = head[WIDTH-1:0];
    assign W_count  = head[EW-1:WIDTH];

endmodule
